// File: rtl/instr_fetch.sv
// Instruction fetch unit for an 8-bit instruction memory.
//
// Owns the fetch PC, drives the memory read address every cycle, captures the
// combinational read data into a DEPTH-entry prefetch queue and presents the
// head to decode with a valid/ready handshake. A redirect from execute flushes
// the queue and restarts fetch at redirect_addr.
//
// Optional feature: define FETCH_HALT_EN to stop fetching after a HALT_OPCODE
// byte has been enqueued. Only redirect or reset resumes fetch.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   addr           instruction memory read address (fetch PC register)
//   instrcode      instruction memory read data, combinational from addr
//   redirect       flush queue and restart fetch at redirect_addr
//   redirect_addr  new fetch PC when redirect is high
//   ir             instruction at queue head
//   ir_pc          address of the instruction at queue head
//   ir_valid       queue non-empty
//   ir_ready       decode accepts the head this cycle
//   full           queue holds DEPTH entries
//   halted         fetch halted (always 0 without FETCH_HALT_EN)
module instr_fetch #(
    parameter int unsigned DEPTH       = 2,
    parameter logic [7:0]  RESET_PC    = 8'h00,
    parameter logic [7:0]  HALT_OPCODE = 8'hff
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] addr,
    input  logic [7:0] instrcode,
    input  logic       redirect,
    input  logic [7:0] redirect_addr,
    output logic [7:0] ir,
    output logic [7:0] ir_pc,
    output logic       ir_valid,
    input  logic       ir_ready,
    output logic       full,
    output logic       halted
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [7:0]    fetch_pc;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [7:0]    q_instr [DEPTH];
    logic [7:0]    q_pc    [DEPTH];

    logic run;
    logic pop;
    logic push;

    // Outputs come from registered queue state only.
    assign addr     = fetch_pc;
    assign ir_valid = (count != '0);
    assign full     = (count == CW'(DEPTH));
    assign ir       = q_instr[rd_ptr];
    assign ir_pc    = q_pc[rd_ptr];

    assign pop  = ir_valid && ir_ready && !redirect;
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign push = run && !redirect && ((count < CW'(DEPTH)) || pop);

`ifdef FETCH_HALT_EN
    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_HALT = 1'b1;

    logic state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
        end else if (redirect) begin
            state <= ST_RUN;
        end else if (push && (instrcode == HALT_OPCODE)) begin
            // The halt byte itself is still enqueued this cycle.
            state <= ST_HALT;
        end
    end

    assign run    = (state == ST_RUN);
    assign halted = (state == ST_HALT);
`else
    logic unused_halt_opcode;

    assign unused_halt_opcode = ^HALT_OPCODE;
    assign run                = 1'b1;
    assign halted             = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_instr[i] <= 8'h00;
                q_pc[i]    <= 8'h00;
            end
        end else if (redirect) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= redirect_addr;
        end else begin
            if (push) begin
                q_instr[wr_ptr] <= instrcode;
                q_pc[wr_ptr]    <= fetch_pc;
                wr_ptr          <= wr_ptr + PW'(1);
                fetch_pc        <= fetch_pc + 8'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam int unsigned DEPTH = 2;

    logic       clk;
    logic       rst;
    logic [7:0] addr;
    logic [7:0] instrcode;
    logic       redirect;
    logic [7:0] redirect_addr;
    logic [7:0] ir;
    logic [7:0] ir_pc;
    logic       ir_valid;
    logic       ir_ready;
    logic       full;
    logic       halted;

    // Second instance used only to observe PC wrap from RESET_PC=fe.
    logic [7:0] addr2;
    logic [7:0] instrcode2;
    logic [7:0] ir2;
    logic [7:0] ir_pc2;
    logic       ir_valid2;
    logic       full2;
    logic       halted2;
    logic       redirect2;
    logic [7:0] redirect_addr2;
    logic       ir_ready2;

    logic [7:0] tb_mem [256];

    int errors = 0;
    int checks = 0;

    assign instrcode  = tb_mem[addr];
    assign instrcode2 = tb_mem[addr2];

    instr_fetch #(.DEPTH(DEPTH), .RESET_PC(8'h00), .HALT_OPCODE(8'hff)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .instrcode     (instrcode),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .ir            (ir),
        .ir_pc         (ir_pc),
        .ir_valid      (ir_valid),
        .ir_ready      (ir_ready),
        .full          (full),
        .halted        (halted)
    );

    instr_fetch #(.DEPTH(DEPTH), .RESET_PC(8'hfe), .HALT_OPCODE(8'hff)) u_wrap (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr2),
        .instrcode     (instrcode2),
        .redirect      (redirect2),
        .redirect_addr (redirect_addr2),
        .ir            (ir2),
        .ir_pc         (ir_pc2),
        .ir_valid      (ir_valid2),
        .ir_ready      (ir_ready2),
        .full          (full2),
        .halted        (halted2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reset held across one negedge, released on the next; reset state checked.
    task automatic do_reset();
        rst           = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 8'h00;
        ir_ready      = 1'b0;
        @(negedge clk);
        chk("rst_valid", {7'd0, ir_valid}, 8'h00);
        chk("rst_full", {7'd0, full}, 8'h00);
        chk("rst_halted", {7'd0, halted}, 8'h00);
        chk("rst_ir", ir, 8'h00);
        chk("rst_ir_pc", ir_pc, 8'h00);
        chk("rst_addr", addr, 8'h00);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] instr;
    } entry_t;

    entry_t     m_q[$];
    logic [7:0] m_pc;
    logic       m_halt;

    task automatic model_reset();
        m_q.delete();
        m_pc   = 8'h00;
        m_halt = 1'b0;
    endtask

    // Inputs as seen just before the edge; queue advanced by one edge.
    task automatic model_edge(input logic rd, input logic [7:0] ra, input logic rdy);
        bit can_pop;
        bit can_push;
        if (rd) begin
            m_q.delete();
            m_pc   = ra;
            m_halt = 1'b0;
        end else begin
            can_pop  = (m_q.size() > 0) && rdy;
            can_push = !m_halt && ((m_q.size() < DEPTH) || can_pop);
            if (can_pop) void'(m_q.pop_front());
            if (can_push) begin
                m_q.push_back('{pc: m_pc, instr: tb_mem[m_pc]});
`ifdef FETCH_HALT_EN
                if (tb_mem[m_pc] == 8'hff) m_halt = 1'b1;
`endif
                m_pc = m_pc + 8'd1;
            end
        end
    endtask

    task automatic model_compare();
        chk("rnd_valid", {7'd0, ir_valid}, {7'd0, m_q.size() > 0});
        chk("rnd_full", {7'd0, full}, {7'd0, m_q.size() == DEPTH});
        chk("rnd_addr", addr, m_pc);
        chk("rnd_halted", {7'd0, halted}, {7'd0, m_halt});
        if (m_q.size() > 0) begin
            chk("rnd_ir", ir, m_q[0].instr);
            chk("rnd_ir_pc", ir_pc, m_q[0].pc);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       redir;
        logic [7:0] raddr;
        logic       rdy;
        logic       exp_valid;
        logic [7:0] exp_ir;
        logic [7:0] exp_pc;
        logic       exp_full;
        logic [7:0] exp_addr;
    } vec_t;

    vec_t       vecs [12];
    logic [7:0] wrap_pc [3];
    logic [7:0] wrap_ir [3];

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 8'(i) ^ 8'ha5;
        tb_mem[0]    = 8'h1b;
        tb_mem[1]    = 8'h73;
        tb_mem[2]    = 8'h4e;
        tb_mem[3]    = 8'hc5;
        tb_mem[4]    = 8'h0c;
        tb_mem[5]    = 8'h59;
        tb_mem[6]    = 8'h6a;
        tb_mem[7]    = 8'h7b;
        tb_mem[8'hfe] = 8'haa;
        tb_mem[8'hff] = 8'hbb;

        //          redir raddr  rdy  valid ir     pc     full  addr
        vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h1b, 8'h00, 1'b0, 8'h01};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h73, 8'h01, 1'b0, 8'h02};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h4e, 8'h02, 1'b0, 8'h03};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hc5, 8'h03, 1'b0, 8'h04};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h0c, 8'h04, 1'b0, 8'h05};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h59, 8'h05, 1'b0, 8'h06};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h59, 8'h05, 1'b1, 8'h07};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h59, 8'h05, 1'b1, 8'h07};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h6a, 8'h06, 1'b1, 8'h08};
        vecs[9]  = '{1'b1, 8'h04, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h04};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h0c, 8'h04, 1'b0, 8'h05};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h59, 8'h05, 1'b0, 8'h06};

        wrap_pc[0] = 8'hfe; wrap_ir[0] = 8'haa;
        wrap_pc[1] = 8'hff; wrap_ir[1] = 8'hbb;
        wrap_pc[2] = 8'h00; wrap_ir[2] = 8'h1b;

        redirect2      = 1'b0;
        redirect_addr2 = 8'h00;
        ir_ready2      = 1'b1;

        // ---- table: streaming, stall to full, redirect while full ----
        do_reset();
        chk("wrap_rst_addr", addr2, 8'hfe);
        for (int i = 0; i < 12; i++) begin
            redirect      = vecs[i].redir;
            redirect_addr = vecs[i].raddr;
            ir_ready      = vecs[i].rdy;
            tick();
            chk($sformatf("v%0d_valid", i), {7'd0, ir_valid}, {7'd0, vecs[i].exp_valid});
            chk($sformatf("v%0d_full", i), {7'd0, full}, {7'd0, vecs[i].exp_full});
            chk($sformatf("v%0d_addr", i), addr, vecs[i].exp_addr);
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d_ir", i), ir, vecs[i].exp_ir);
                chk($sformatf("v%0d_ir_pc", i), ir_pc, vecs[i].exp_pc);
            end
            if (i < 3) begin
                chk($sformatf("wrap%0d_ir_pc", i), ir_pc2, wrap_pc[i]);
                chk($sformatf("wrap%0d_ir", i), ir2, wrap_ir[i]);
            end
        end
        redirect = 1'b0;

        // ---- stall after reset: fill, hold, drain without loss ----
        do_reset();
        tick();
        tick();
        chk("stall_full", {7'd0, full}, 8'h01);
        chk("stall_ir", ir, 8'h1b);
        chk("stall_ir_pc", ir_pc, 8'h00);
        chk("stall_addr", addr, 8'h02);
        tick();
        chk("stall_hold_ir", ir, 8'h1b);
        chk("stall_hold_addr", addr, 8'h02);
        ir_ready = 1'b1;
        tick();
        chk("drain0_ir", ir, 8'h73);
        chk("drain0_ir_pc", ir_pc, 8'h01);
        tick();
        chk("drain1_ir", ir, 8'h4e);
        chk("drain1_ir_pc", ir_pc, 8'h02);

        // ---- asynchronous reset mid-stream with two entries queued ----
        ir_ready = 1'b0;
        tick();
        chk("pre_async_full", {7'd0, full}, 8'h01);
        rst = 1'b0;
        #1;
        chk("async_valid", {7'd0, ir_valid}, 8'h00);
        chk("async_full", {7'd0, full}, 8'h00);
        chk("async_addr", addr, 8'h00);
        @(negedge clk);
        rst = 1'b1;

`ifdef FETCH_HALT_EN
        // ---- halt opcode stops fetch; redirect resumes ----
        tb_mem[2] = 8'hff;
        do_reset();
        ir_ready = 1'b1;
        tick(); chk("halt_ir0", ir, 8'h1b);
        tick(); chk("halt_ir1", ir, 8'h73);
        tick(); chk("halt_ir2", ir, 8'hff);
        chk("halt_flag", {7'd0, halted}, 8'h01);
        tick();
        chk("halt_empty", {7'd0, ir_valid}, 8'h00);
        chk("halt_still", {7'd0, halted}, 8'h01);
        chk("halt_addr", addr, 8'h03);
        redirect      = 1'b1;
        redirect_addr = 8'h00;
        tick();
        redirect = 1'b0;
        chk("unhalt_flag", {7'd0, halted}, 8'h00);
        tick();
        chk("unhalt_ir", ir, 8'h1b);
        tb_mem[2] = 8'h4e;
`endif

        // ---- randomized stimulus against the queue model ----
        do_reset();
        model_reset();
        for (int n = 0; n < 2000; n++) begin
            redirect      = ($urandom_range(0, 99) < 5);
            redirect_addr = 8'($urandom_range(0, 255));
            ir_ready      = ($urandom_range(0, 99) < 65);
            model_edge(redirect, redirect_addr, ir_ready);
            tick();
            model_compare();
        end
        redirect = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
